// File: rtl/music_pkg.sv
// Shared types and defaults for the music player playback path.
package music_pkg;

    localparam int unsigned DEF_BEAT_COUNT = 1000;
    localparam int unsigned DEF_NUM_SONGS  = 4;
    localparam int unsigned DEF_SONG_W     = 2;
    localparam int unsigned DEF_NOTE_IDX_W = 5;
    localparam int unsigned DEF_NOTE_W     = 6;
    localparam int unsigned DEF_DUR_W      = 6;

    // Note code 0 is a rest; it is timed like any other note.
    localparam int unsigned REST_NOTE = 0;

    // Sequencer phases: address out, ROM latency, decode, sustain, song wrap-up.
    typedef enum logic [2:0] {
        StFetch,
        StWait,
        StLoad,
        StHold,
        StEnd
    } seq_state_e;

    // Song index that follows `song`, wrapping at num_songs.
    function automatic int unsigned next_song(input int unsigned song,
                                              input int unsigned num_songs);
        return (song + 1 >= num_songs) ? 0 : song + 1;
    endfunction

endpackage

// File: rtl/beat_generator.sv
// Beat pacing counter: advances only while enabled, pulses beat on wrap.
module beat_generator #(
    parameter int unsigned BEAT_COUNT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic beat
);

    localparam int unsigned CntW = (BEAT_COUNT > 1) ? $clog2(BEAT_COUNT) : 1;

    logic [CntW-1:0] count_q, count_d;
    logic            at_max;

    assign at_max = (count_q == CntW'(BEAT_COUNT - 1));
    // A clear in the wrap cycle wins, so no beat escapes a song change.
    assign beat   = enable & ~clear & at_max;

    // Next count: clear has priority, then wrap or increment while enabled.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = at_max ? '0 : count_q + CntW'(1);
        end
    end

    // Count register; pausing simply leaves it frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Playback controller: walks the song ROM note by note, paces each note in
// beats and handles the play/pause and next-song buttons.
module song_sequencer
    import music_pkg::*;
#(
    parameter int unsigned BEAT_COUNT = DEF_BEAT_COUNT,
    parameter int unsigned NUM_SONGS  = DEF_NUM_SONGS,
    parameter int unsigned SONG_W     = DEF_SONG_W,
    parameter int unsigned NOTE_IDX_W = DEF_NOTE_IDX_W,
    parameter int unsigned NOTE_W     = DEF_NOTE_W,
    parameter int unsigned DUR_W      = DEF_DUR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play_button,
    input  logic                         next_button,
    output logic [SONG_W+NOTE_IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]      rom_data,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         note_load,
    output logic                         play_enable,
    output logic [SONG_W-1:0]            current_song,
    output logic                         beat,
    output logic                         song_done
);

    seq_state_e              state_q, state_d;
    logic                    playing_q, playing_d;
    logic [SONG_W-1:0]       song_q, song_d;
    logic [NOTE_IDX_W-1:0]   note_idx_q, note_idx_d;
    logic [NOTE_W-1:0]       note_q, note_d;
    logic [DUR_W-1:0]        dur_cnt_q, dur_cnt_d;
    logic                    note_load_q, note_load_d;

    logic [NOTE_W-1:0]       rom_note;
    logic [DUR_W-1:0]        rom_dur;
    logic [SONG_W-1:0]       song_inc;
    logic                    beat_clear;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    assign song_inc = SONG_W'(next_song(32'(song_q), NUM_SONGS));

    // Beat phase restarts with every new song, whether chosen or reached.
    assign beat_clear = next_button | (state_q == StEnd);

    beat_generator #(
        .BEAT_COUNT (BEAT_COUNT)
    ) u_beat_generator (
        .clk    (clk),
        .reset  (reset),
        .enable (playing_q),
        .clear  (beat_clear),
        .beat   (beat)
    );

    assign rom_addr     = {song_q, note_idx_q};
    assign note_out     = note_q;
    assign note_load    = note_load_q;
    assign play_enable  = playing_q;
    assign current_song = song_q;
    assign song_done    = (state_q == StEnd);

    // Next-state: sequencing advances only while playing; END always completes
    // in one cycle so song_done is a clean single pulse; next overrides all.
    always_comb begin
        state_d     = state_q;
        playing_d   = playing_q;
        song_d      = song_q;
        note_idx_d  = note_idx_q;
        note_d      = note_q;
        dur_cnt_d   = dur_cnt_q;
        note_load_d = 1'b0;

        if (play_button) begin
            playing_d = ~playing_q;
        end

        if (state_q == StEnd) begin
            // A next press here is absorbed: the song advances exactly once.
            song_d     = song_inc;
            note_idx_d = '0;
            playing_d  = 1'b0;
            state_d    = StFetch;
        end else begin
            if (playing_q) begin
                unique case (state_q)
                    StFetch: begin
                        state_d = StWait;
                    end
                    StWait: begin
                        // ROM word is valid now; capture it so LOAD can
                        // present note_load without a further cycle.
                        dur_cnt_d = rom_dur;
                        if (rom_dur != '0) begin
                            note_d      = rom_note;
                            note_load_d = 1'b1;
                        end
                        state_d = StLoad;
                    end
                    StLoad: begin
                        state_d = (dur_cnt_q == '0) ? StEnd : StHold;
                    end
                    StHold: begin
                        if (beat) begin
                            if (dur_cnt_q == DUR_W'(1)) begin
                                if (note_idx_q == '1) begin
                                    state_d = StEnd;
                                end else begin
                                    note_idx_d = note_idx_q + NOTE_IDX_W'(1);
                                    state_d    = StFetch;
                                end
                            end else begin
                                dur_cnt_d = dur_cnt_q - DUR_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = StFetch;
                    end
                endcase
            end

            if (next_button) begin
                // note_out is kept; play_enable=0 mutes it downstream.
                song_d      = song_inc;
                note_idx_d  = '0;
                playing_d   = 1'b0;
                state_d     = StFetch;
                note_d      = note_q;
                dur_cnt_d   = dur_cnt_q;
                note_load_d = 1'b0;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFetch;
            playing_q   <= 1'b0;
            song_q      <= '0;
            note_idx_q  <= '0;
            note_q      <= NOTE_W'(REST_NOTE);
            dur_cnt_q   <= '0;
            note_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            playing_q   <= playing_d;
            song_q      <= song_d;
            note_idx_q  <= note_idx_d;
            note_q      <= note_d;
            dur_cnt_q   <= dur_cnt_d;
            note_load_q <= note_load_d;
        end
    end

endmodule
